// File: rtl/axi_sram_pkg.sv
// Shared encodings, request payload and address helpers for the AXI4 SRAM slave.
package axi_sram_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } axReq_t;

    // WRAP is treated as INCR; the reserved encoding is flagged elsewhere as an error.
    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                   input logic [2:0]        size,
                                                   input logic [1:0]        burst);
        logic [ADDR_W-1:0] stepped;
        stepped = addr + (ADDR_W'(1) << size);
        unique case (burst)
            BURST_FIXED:            return addr;
            BURST_INCR, BURST_WRAP: return stepped;
            default:                return stepped;
        endcase
    endfunction

    function automatic logic isBadReq(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Single-port word RAM with byte enables, synchronous write and registered read.
module axi_sram_mem #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned ADDR_BITS   = 11,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic [ADDR_BITS-1:0]    addr,
    input  logic                    wrEn,
    input  logic [DATA_WIDTH/8-1:0] wrStrb,
    input  logic [DATA_WIDTH-1:0]   wrData,
    output logic [DATA_WIDTH-1:0]   rdData
);

    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (wrStrb[i]) begin
                    mem[addr][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
        end
        rdData <= mem[addr];
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by an 8 KiB byte-writable RAM; serves one transaction at a time.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    slaveAxi_aw_valid,
    output logic                    slaveAxi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   slaveAxi_aw_payload_addr,
    input  logic [7:0]              slaveAxi_aw_payload_len,
    input  logic [2:0]              slaveAxi_aw_payload_size,
    input  logic [1:0]              slaveAxi_aw_payload_burst,
    input  logic                    slaveAxi_w_valid,
    output logic                    slaveAxi_w_ready,
    input  logic [DATA_WIDTH-1:0]   slaveAxi_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0] slaveAxi_w_payload_strb,
    input  logic                    slaveAxi_w_payload_last,
    output logic                    slaveAxi_b_valid,
    input  logic                    slaveAxi_b_ready,
    output logic [1:0]              slaveAxi_b_payload_resp,
    input  logic                    slaveAxi_ar_valid,
    output logic                    slaveAxi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   slaveAxi_ar_payload_addr,
    input  logic [7:0]              slaveAxi_ar_payload_len,
    input  logic [2:0]              slaveAxi_ar_payload_size,
    input  logic [1:0]              slaveAxi_ar_payload_burst,
    output logic                    slaveAxi_r_valid,
    input  logic                    slaveAxi_r_ready,
    output logic [DATA_WIDTH-1:0]   slaveAxi_r_payload_data,
    output logic [1:0]              slaveAxi_r_payload_resp,
    output logic                    slaveAxi_r_payload_last
);

    localparam int unsigned WORD_BITS = ADDR_WIDTH - 2;

    state_t                state, stateNext;
    axReq_t                req, awReq, arReq, selReq;
    logic [7:0]            beat;
    logic                  err;
    logic                  writeFirst;
    logic                  grantWrite, grantRead;
    logic                  lastBeat, wFire, rFire;
    logic [ADDR_W-1:0]     stepAddr;
    logic [WORD_BITS-1:0]  ramAddr;
    logic                  ramWrEn;
    logic [DATA_WIDTH-1:0] ramRdData;

    assign awReq = '{addr: ADDR_W'(slaveAxi_aw_payload_addr), len: slaveAxi_aw_payload_len,
                     size: slaveAxi_aw_payload_size, burst: slaveAxi_aw_payload_burst};
    assign arReq = '{addr: ADDR_W'(slaveAxi_ar_payload_addr), len: slaveAxi_ar_payload_len,
                     size: slaveAxi_ar_payload_size, burst: slaveAxi_ar_payload_burst};
    assign selReq   = grantWrite ? awReq : arReq;
    assign lastBeat = (beat == req.len);
    assign wFire    = (state == WDATA) && slaveAxi_w_valid;
    assign rFire    = (state == RDATA) && slaveAxi_r_ready;
    assign stepAddr = nextAddr(req.addr, req.size, req.burst);
    assign ramWrEn  = wFire && !err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, arbitration and handshake outputs.
    always_comb begin
        stateNext               = state;
        grantWrite              = 1'b0;
        grantRead               = 1'b0;
        slaveAxi_w_ready        = 1'b0;
        slaveAxi_b_valid        = 1'b0;
        slaveAxi_b_payload_resp = RESP_OKAY;
        slaveAxi_r_valid        = 1'b0;
        slaveAxi_r_payload_last = 1'b0;
        slaveAxi_r_payload_resp = RESP_OKAY;
        slaveAxi_r_payload_data = '0;
        unique case (state)
            IDLE: begin
                if (!reset && slaveAxi_aw_valid && (!slaveAxi_ar_valid || writeFirst)) begin
                    grantWrite = 1'b1;
                    stateNext  = WDATA;
                end else if (!reset && slaveAxi_ar_valid) begin
                    grantRead = 1'b1;
                    stateNext = RDATA;
                end
            end
            WDATA: begin
                slaveAxi_w_ready = 1'b1;
                if (slaveAxi_w_valid && lastBeat) stateNext = WRESP;
            end
            WRESP: begin
                slaveAxi_b_valid        = 1'b1;
                slaveAxi_b_payload_resp = err ? RESP_SLVERR : RESP_OKAY;
                if (slaveAxi_b_ready) stateNext = IDLE;
            end
            RDATA: begin
                slaveAxi_r_valid        = 1'b1;
                slaveAxi_r_payload_last = lastBeat;
                slaveAxi_r_payload_resp = err ? RESP_SLVERR : RESP_OKAY;
                slaveAxi_r_payload_data = err ? '0 : ramRdData;
                if (slaveAxi_r_ready && lastBeat) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign slaveAxi_aw_ready = grantWrite;
    assign slaveAxi_ar_ready = grantRead;

    // Request capture, beat counting and error tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req        <= '0;
            beat       <= '0;
            err        <= 1'b0;
            writeFirst <= 1'b1;
        end else if (grantWrite || grantRead) begin
            req        <= selReq;
            beat       <= '0;
            err        <= isBadReq(selReq.size, selReq.burst);
            writeFirst <= !writeFirst;
        end else if (wFire) begin
            beat <= beat + 8'd1;
            req.addr <= stepAddr;
            if (slaveAxi_w_payload_last != lastBeat) err <= 1'b1;
        end else if (rFire && !lastBeat) begin
            beat <= beat + 8'd1;
            req.addr <= stepAddr;
        end
    end

    // Prefetch the next read word on the same edge as the R handshake.
    always_comb begin
        ramAddr = WORD_BITS'(req.addr >> 2);
        if (grantRead) begin
            ramAddr = WORD_BITS'(arReq.addr >> 2);
        end else if (rFire && !lastBeat) begin
            ramAddr = WORD_BITS'(stepAddr >> 2);
        end
    end

    axi_sram_mem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_BITS  (WORD_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) uMem (
        .clk   (clk),
        .addr  (ramAddr),
        .wrEn  (ramWrEn),
        .wrStrb(slaveAxi_w_payload_strb),
        .wrData(slaveAxi_w_payload_data),
        .rdData(ramRdData)
    );

endmodule
